// File: rtl/aes256_decrypt_sequencer.sv
// Iterative AES-256 decryptor: caches 15 round keys, then 14 inverse rounds per block through shared units.
// Latency 23 cycles (new key) / 16 (cached); one block in flight; DONE holds out_data until out_ready.
module aes256_decrypt_sequencer #(
  parameter int KEY_W = 256,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_newkey,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic [3:0]       ke_rc,
  output logic [KEY_W-1:0] ke_keyin,
  input  logic [KEY_W-1:0] ke_keyout,
  output logic [BLK_W-1:0] rnd_in,
  output logic [BLK_W-1:0] rnd_key,
  output logic             rnd_last,
  input  logic [BLK_W-1:0] rnd_out
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic             run_q;
  logic             keys_valid_q, keys_valid_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0] kexp_q, kexp_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic [BLK_W-1:0] rk_q [15];
  logic [BLK_W-1:0] rk_d [15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= IDLE;
      run_q        <= 1'b0;
      keys_valid_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= '0;
      kexp_q       <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end else begin
      fsm_q        <= fsm_d;
      run_q        <= 1'b1;
      keys_valid_q <= keys_valid_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      kexp_q       <= kexp_d;
      out_data_q   <= out_data_d;
      for (int i = 0; i < 15; i++) rk_q[i] <= rk_d[i];
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    keys_valid_d = keys_valid_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    kexp_d       = kexp_q;
    out_data_d   = out_data_q;
    rk_d         = rk_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    ke_rc        = '0;
    ke_keyin     = '0;
    rnd_key      = '0;
    rnd_last     = 1'b0;
    case (fsm_q)
      IDLE: begin
        // run_q keeps in_ready low until the first edge after reset release
        in_ready = run_q;
        if (in_valid && run_q) begin
          state_d = in_data;
          if (in_newkey || !keys_valid_q) begin
            kexp_d  = in_key;
            rk_d[0] = in_key[KEY_W-1:BLK_W];
            rk_d[1] = in_key[BLK_W-1:0];
            cnt_d   = 4'd0;
            fsm_d   = KEXP;
          end else begin
            cnt_d = 4'd14;
            fsm_d = ROUND;
          end
        end
      end
      KEXP: begin
        ke_rc    = cnt_q;
        ke_keyin = kexp_q;
        kexp_d   = ke_keyout;
        rk_d[{cnt_q[2:0], 1'b0} + 4'd2] = ke_keyout[KEY_W-1:BLK_W];
        if (cnt_q == 4'd6) begin
          keys_valid_d = 1'b1;
          cnt_d        = 4'd14;
          fsm_d        = ROUND;
        end else begin
          rk_d[{cnt_q[2:0], 1'b0} + 4'd3] = ke_keyout[BLK_W-1:0];
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        if (cnt_q == 4'd14) begin
          state_d = state_q ^ rk_q[14];
          cnt_d   = cnt_q - 4'd1;
        end else if (cnt_q == 4'd0) begin
          rnd_key    = rk_q[0];
          rnd_last   = 1'b1;
          out_data_d = rnd_out;
          fsm_d      = DONE;
        end else begin
          rnd_key = rk_q[cnt_q];
          state_d = rnd_out;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign rnd_in   = state_q;
  assign busy     = (fsm_q != IDLE);
  assign out_data = out_data_q;

endmodule

// File: tb/tb_aes256_decrypt_sequencer.sv
// Bench for aes256_decrypt_sequencer: behavioural keyExpansion and inverse-round units, vector table plus reset-abort sequence.
module tb_aes256_decrypt_sequencer;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_A  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] CT_B1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] PT_B1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_B2 = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] PT_B2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_newkey;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   ke_rc;
  logic [255:0] ke_keyin, ke_keyout;
  logic [127:0] rnd_in, rnd_key, rnd_out;
  logic         rnd_last;

  int checks = 0;
  int errors = 0;

  aes256_decrypt_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_newkey(in_newkey),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
    .ke_rc(ke_rc), .ke_keyin(ke_keyin), .ke_keyout(ke_keyout),
    .rnd_in(rnd_in), .rnd_key(rnd_key), .rnd_last(rnd_last), .rnd_out(rnd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-256 schedule step: eight words in, next eight words out.
  function automatic logic [255:0] kexp_f(input logic [255:0] k, input logic [3:0] rc);
    logic [31:0] w [8];
    logic [31:0] o [8];
    logic [7:0]  rcon;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rcon = 8'h01 << rc;
    o[0] = w[0] ^ subword({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
    for (int i = 1; i < 4; i++) o[i] = w[i] ^ o[i-1];
    o[4] = w[4] ^ subword(o[3]);
    for (int i = 5; i < 8; i++) o[i] = w[i] ^ o[i-1];
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = o[i];
    return r;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        b[4*col+row] = isbox(a[4*((col-row+4)%4)+row]) ^ k[127-8*(4*col+row) -: 8];
    for (int col = 0; col < 4; col++) begin
      if (last) begin
        for (int row = 0; row < 4; row++) m[4*col+row] = b[4*col+row];
      end else begin
        m[4*col+0] = gmul(b[4*col],8'h0e) ^ gmul(b[4*col+1],8'h0b) ^ gmul(b[4*col+2],8'h0d) ^ gmul(b[4*col+3],8'h09);
        m[4*col+1] = gmul(b[4*col],8'h09) ^ gmul(b[4*col+1],8'h0e) ^ gmul(b[4*col+2],8'h0b) ^ gmul(b[4*col+3],8'h0d);
        m[4*col+2] = gmul(b[4*col],8'h0d) ^ gmul(b[4*col+1],8'h09) ^ gmul(b[4*col+2],8'h0e) ^ gmul(b[4*col+3],8'h0b);
        m[4*col+3] = gmul(b[4*col],8'h0b) ^ gmul(b[4*col+1],8'h0d) ^ gmul(b[4*col+2],8'h09) ^ gmul(b[4*col+3],8'h0e);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i];
    return r;
  endfunction

  assign ke_keyout = kexp_f(ke_keyin, ke_rc);
  assign rnd_out   = inv_round(rnd_in, rnd_key, rnd_last);

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         newkey;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
    int           stall;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input string nm);
    int   w, lat, kcyc;
    logic done, quiet_ok, seq_ok, ke_ok, stall_ok;
    logic [127:0] held;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_key    = v.key;
    in_data   = v.ct;
    in_newkey = v.newkey;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_key    = ~v.key;
    in_data   = ~v.ct;
    in_newkey = ~v.newkey;
    kcyc = (v.lat == 23) ? 7 : 0;
    lat = 0;
    done = 1'b0;
    quiet_ok = 1'b1;
    seq_ok = 1'b1;
    ke_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (!done) begin
        @(negedge clk);
        if (out_valid) begin
          done = 1'b1;
          lat = i;
        end else begin
          if (in_ready || !busy) quiet_ok = 1'b0;
          if (i <= kcyc) begin
            if (ke_rc != 4'(i - 1)) seq_ok = 1'b0;
          end else if (ke_rc != 4'd0 || ke_keyin != '0) begin
            ke_ok = 1'b0;
          end
          if (rnd_last != (i == v.lat - 1)) seq_ok = 1'b0;
        end
      end
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_plaintext"}, out_data, v.pt);
    chk({nm, "_busy_quiet"}, quiet_ok, 1);
    chk({nm, "_rc_last_seq"}, seq_ok, 1);
    chk({nm, "_ke_idle"}, ke_ok, 1);
    held = out_data;
    stall_ok = 1'b1;
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_data !== held) stall_ok = 1'b0;
    end
    if (v.stall > 0) chk({nm, "_stall_hold"}, {stall_ok, out_data}, {1'b1, v.pt});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_after_out_hs"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{newkey: 1'b0, key: KEY_A, ct: CT_A,  pt: PT_A,  lat: 23, stall: 0};
    vecs[1] = '{newkey: 1'b0, key: KEY_A, ct: CT_A,  pt: PT_A,  lat: 16, stall: 0};
    vecs[2] = '{newkey: 1'b1, key: KEY_A, ct: CT_A,  pt: PT_A,  lat: 23, stall: 10};
    vecs[3] = '{newkey: 1'b1, key: KEY_B, ct: CT_B1, pt: PT_B1, lat: 23, stall: 0};
    vecs[4] = '{newkey: 1'b0, key: KEY_B, ct: CT_B2, pt: PT_B2, lat: 16, stall: 3};
    vecs[5] = '{newkey: 1'b1, key: KEY_A, ct: CT_A,  pt: PT_A,  lat: 23, stall: 0};
    vecs[6] = '{newkey: 1'b1, key: KEY_A, ct: CT_A,  pt: PT_A,  lat: 23, stall: 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_newkey = 1'b0;
    in_key = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_handshake", {in_ready, out_valid, busy}, 3'b000);
    chk("rst_out_data", out_data, 0);
    chk("rst_ke", {ke_rc, ke_keyin[251:0]}, 0);
    chk("rst_rnd", {rnd_last, rnd_key, rnd_in}, 0);
    rst = 1'b0;

    for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("v%0d", n));

    // Abort during expansion: the cached schedule must be invalidated.
    while (!in_ready) @(negedge clk);
    in_valid  = 1'b1;
    in_key    = KEY_B;
    in_data   = CT_B1;
    in_newkey = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_kexp_cnt3", {busy, ke_rc}, {1'b1, 4'd3});
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, in_ready, out_valid, ke_rc}, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{newkey: 1'b0, key: KEY_A, ct: CT_A, pt: PT_A, lat: 23, stall: 0}, "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
